// File: rtl/gemm_conv_scheduler.sv
// gemm_conv_scheduler: job sequencer and result collector for the GEMM convolution datapath.
// Optional watchdog enabled by defining GEMM_SCHED_TIMEOUT_EN.
module gemm_conv_scheduler #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 8,
    parameter int OBUF_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   img_row,
    input  logic [ADDR_WIDTH-1:0]   img_col,
    input  logic [ADDR_WIDTH-1:0]   ker_row,
    input  logic [ADDR_WIDTH-1:0]   ker_col,
    input  logic [ADDR_WIDTH-1:0]   out_base,
    output logic                    conv_en,
    input  logic                    mac_valid_in,
    input  logic [2*DATA_WIDTH-1:0] mac_in,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [2*DATA_WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int TW = 2*ADDR_WIDTH;
    localparam int DW = 2*DATA_WIDTH;
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] img_row_q, img_row_d, img_col_q, img_col_d;
    logic [ADDR_WIDTH-1:0] ker_row_q, ker_row_d, ker_col_q, ker_col_d;
    logic [ADDR_WIDTH-1:0] out_base_q, out_base_d, tx_cnt_q, tx_cnt_d;
    logic [TW-1:0] total_q, total_d, rx_cnt_q, rx_cnt_d, h_span, w_span;
    logic [DW-1:0] mem_q [OBUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic bad_q, bad_d, ovf_q, ovf_d, abt_q, abt_d;
    logic conv_en_q, conv_en_d, wr_valid_q, wr_valid_d, busy_q, busy_d;
    logic done_q, done_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic accept, active, tmo, flush, push, pop, full, push_ok, drop, bad_dims, last_beat;

`ifdef GEMM_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    assign wd_cnt_d = (state_q == RUN && !mac_valid_in) ? wd_cnt_q + 32'd1 : 32'd0;
    assign tmo = (state_q == RUN) && !mac_valid_in && (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk) wd_cnt_q <= rst ? 32'd0 : wd_cnt_d;
`else
    logic unused_timeout_cfg;
    assign tmo = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        accept     = (state_q == IDLE) && start;
        active     = (state_q == CHECK) || (state_q == RUN) || (state_q == DRAIN);
        flush      = (abort && active) || tmo;
        push       = (state_q == RUN) && mac_valid_in;
        pop        = wr_valid_q && wr_ready;
        full       = cnt_q == CW'(OBUF_DEPTH);
        push_ok    = push && (!full || pop);
        drop       = push && full && !pop;
        img_row_d  = accept ? img_row : img_row_q;
        img_col_d  = accept ? img_col : img_col_q;
        ker_row_d  = accept ? ker_row : ker_row_q;
        ker_col_d  = accept ? ker_col : ker_col_q;
        out_base_d = accept ? out_base : out_base_q;
        bad_dims   = (img_row_q == '0) || (img_col_q == '0) || (ker_row_q == '0) ||
                     (ker_col_q == '0) || (ker_row_q > img_row_q) || (ker_col_q > img_col_q);
        h_span     = TW'(img_row_q) - TW'(ker_row_q) + TW'(1);
        w_span     = TW'(img_col_q) - TW'(ker_col_q) + TW'(1);
        total_d    = (state_q == CHECK) ? h_span * w_span : total_q;
        last_beat  = push && (rx_cnt_q + TW'(1) == total_q);
        rx_cnt_d   = (state_q == DONE) ? '0 : rx_cnt_q + TW'(push);
        tx_cnt_d   = (state_q == DONE) ? '0 : tx_cnt_q + ADDR_WIDTH'(pop);
        cnt_d      = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop);
        wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(pop);
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = start ? CHECK : IDLE;
            CHECK:   state_d = bad_dims ? DONE : RUN;
            RUN:     state_d = last_beat ? DRAIN : RUN;
            DRAIN:   state_d = (cnt_d == '0) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = DONE;
        bad_d      = (state_q == DONE) ? 1'b0 : (state_q == CHECK) ? bad_dims : bad_q;
        ovf_d      = (state_q == DONE) ? 1'b0 : ovf_q || drop;
        abt_d      = (state_q == DONE) ? 1'b0 : abt_q || flush;
        conv_en_d  = state_d == RUN;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
        err_d      = done_d && (bad_d || ovf_d || abt_d);
        wr_valid_d = cnt_d != '0;
        wr_addr_d  = out_base_d + tx_cnt_d;
        // a pushed beat becomes the head when nothing else remains after this cycle's pop
        wr_data_d  = (cnt_q == CW'(pop)) ? mac_in : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk)
        if (push_ok) mem_q[wr_ptr_q] <= mac_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            img_row_q  <= '0;
            img_col_q  <= '0;
            ker_row_q  <= '0;
            ker_col_q  <= '0;
            out_base_q <= '0;
            total_q    <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            ovf_q      <= 1'b0;
            abt_q      <= 1'b0;
            conv_en_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            img_row_q  <= img_row_d;
            img_col_q  <= img_col_d;
            ker_row_q  <= ker_row_d;
            ker_col_q  <= ker_col_d;
            out_base_q <= out_base_d;
            total_q    <= total_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            ovf_q      <= ovf_d;
            abt_q      <= abt_d;
            conv_en_q  <= conv_en_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign conv_en  = conv_en_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule
